mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width on all address ports.
REQ-002 Parameter DATA_W, default 32, data width; byte-mask width is DATA_W/8.
REQ-003 Parameter TIMEOUT, default 16, max cycles to wait for mem_valid after issue (range 2..255).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 if_req  input  1  instruction-fetch request, level, held until if_valid.
REQ-007 if_addr  input  ADDR_W  fetch word address.
REQ-008 if_rdata  output  DATA_W  fetched word, meaningful while if_valid=1.
REQ-009 if_valid  output  1  one-cycle fetch completion pulse.
REQ-010 if_err  output  1  fetch timed out, qualified by if_valid.
REQ-011 d_req  input  1  data request, level, held until d_valid.
REQ-012 d_we  input  1  1=store, 0=load.
REQ-013 d_addr  input  ADDR_W  data word address.
REQ-014 d_wdata  input  DATA_W  store data.
REQ-015 d_mask  input  DATA_W/8  store byte enables.
REQ-016 d_rdata  output  DATA_W  load data, meaningful while d_valid=1.
REQ-017 d_valid  output  1  one-cycle data completion pulse.
REQ-018 d_err  output  1  data access timed out, qualified by d_valid.
REQ-019 mem_request  output  1  one-cycle issue strobe to the shared RAM.
REQ-020 mem_address  output  ADDR_W  registered RAM address.
REQ-021 mem_w_en  output  1  registered write enable.
REQ-022 mem_write_data  output  DATA_W  registered write data.
REQ-023 mem_masking  output  DATA_W/8  registered byte mask (0 for fetches and loads).
REQ-024 mem_read_data  input  DATA_W  RAM read data, valid with mem_valid.
REQ-025 mem_valid  input  1  RAM completion, one cycle, at least one cycle after mem_request.

Function
REQ-026 FSM states: IDLE, WAIT_I, WAIT_D; one transaction outstanding at most.
REQ-027 IDLE: eligible requester = req high and its own valid not high this cycle (mask prevents reissue while requester drops req).
REQ-028 IDLE, one eligible: grant it; both eligible: grant the one not granted last (round-robin); none: stay IDLE.
REQ-029 On grant, next edge: mem_request=1 for exactly one cycle, mem_address/mem_w_en/mem_write_data/mem_masking loaded from the granted port (fetch: w_en=0, mask=0), state -> WAIT_I or WAIT_D, last-grant updated.
REQ-030 mem_address/w_en/write_data/masking hold stable from issue until return to IDLE.
REQ-031 WAIT_x with mem_valid=1: next edge x_rdata<=mem_read_data, x_valid=1 and x_err=0 for one cycle, state -> IDLE.
REQ-032 Timeout counter clears on issue, increments each WAIT cycle without mem_valid; at count TIMEOUT-1 next edge x_valid=1, x_err=1, x_rdata=0, state -> IDLE.
REQ-033 mem_valid on the same cycle as the timeout count: mem_valid wins, no error.
REQ-034 mem_valid received in IDLE (late response) is ignored.
REQ-035 Minimum grant-to-valid latency: 3 cycles (issue, mem_valid, registered valid); back-to-back throughput one access per 3 cycles.
REQ-036 Requests or input changes while in WAIT_x are not sampled; only IDLE samples.
REQ-037 x_rdata holds its last value when x_valid=0.

Reset
REQ-038 rst=0 immediately forces state IDLE, counter 0, last-grant = data (fetch wins first tie), all outputs 0.
REQ-039 Reset during WAIT_x aborts silently: no valid pulse after release; an already issued RAM write may still complete.
REQ-040 First grant possible on the first rising edge after rst deasserts.

Structure
REQ-041 Shared package mem_arb_pkg holds the state encoding and grant-id constants (GNT_I, GNT_D).
REQ-042 One sub-module rr_arb2: 2-way round-robin picker (two requests, last-grant in, one-hot grant out), combinational.

Verification
REQ-043 Fetch only: if_req, if_addr=0x04, mem returns 0x00000013 one cycle after issue -> if_valid pulse 3 cycles after req, if_rdata=0x00000013, if_err=0.
REQ-044 Store: d_req, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF, d_mask=4'b0011 -> mem_w_en=1, mem_address=0x10, mem_masking=4'b0011 stable until d_valid.
REQ-045 Contention from reset: both req held high continuously -> grant order I, D, I, D; no port served twice in a row.
REQ-046 Timeout: d_req load, mem_valid never asserted, TIMEOUT=16 -> d_valid with d_err=1, d_rdata=0 exactly 16 WAIT cycles after issue; next request served normally.
REQ-047 Reset mid-WAIT_I: rst low 2 cycles, mem_valid arrives after release -> no if_valid, all outputs 0, state IDLE.
REQ-048 Late response: mem_valid pulsed in IDLE -> no valid pulse on either port, no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding and grant identifiers for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker, one-hot grant {data, fetch}
import mem_arb_pkg::*;
module rr_arb2 (
  input  logic       req_i,
  input  logic       req_d,
  input  logic       last,
  output logic [1:0] gnt
);
  // on a tie the port not granted last wins
  always_comb begin
    gnt[0] = req_i & (~req_d | (last == GNT_D));
    gnt[1] = req_d & (~req_i | (last == GNT_I));
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between fetch and data requesters, one access outstanding
import mem_arb_pkg::*;
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_mask,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_err,
  output logic                mem_request,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_w_en,
  output logic [DATA_W-1:0]   mem_write_data,
  output logic [DATA_W/8-1:0] mem_masking,
  input  logic [DATA_W-1:0]   mem_read_data,
  input  logic                mem_valid
);
  localparam int MW = DATA_W / 8;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t     state;
  logic       last;
  logic [7:0] cnt;
  logic [1:0] gnt;
  logic       done;
  // a port whose completion pulse is high this cycle is not eligible, so a held req is not reissued
  rr_arb2 u_arb (
    .req_i (if_req & ~if_valid),
    .req_d (d_req & ~d_valid),
    .last  (last),
    .gnt   (gnt)
  );
  // wait ends on a RAM response or when the timeout count is reached; the response wins a tie
  always_comb done = mem_valid | (cnt == LAST);
  // arbitration FSM with registered RAM and completion outputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state          <= IDLE;
      last           <= GNT_D;
      cnt            <= '0;
      mem_request    <= 1'b0;
      mem_address    <= '0;
      mem_w_en       <= 1'b0;
      mem_write_data <= '0;
      mem_masking    <= '0;
      if_rdata       <= '0;
      if_valid       <= 1'b0;
      if_err         <= 1'b0;
      d_rdata        <= '0;
      d_valid        <= 1'b0;
      d_err          <= 1'b0;
    end else begin
      mem_request <= 1'b0;
      if_valid    <= 1'b0;
      if_err      <= 1'b0;
      d_valid     <= 1'b0;
      d_err       <= 1'b0;
      case (state)
        IDLE:
          if (gnt[0]) begin
            mem_request    <= 1'b1;
            mem_address    <= if_addr;
            mem_w_en       <= 1'b0;
            mem_write_data <= '0;
            mem_masking    <= '0;
            last           <= GNT_I;
            cnt            <= '0;
            state          <= WAIT_I;
          end else if (gnt[1]) begin
            mem_request    <= 1'b1;
            mem_address    <= d_addr;
            mem_w_en       <= d_we;
            mem_write_data <= d_wdata;
            mem_masking    <= d_mask & {MW{d_we}};
            last           <= GNT_D;
            cnt            <= '0;
            state          <= WAIT_D;
          end
        WAIT_I, WAIT_D:
          if (done) begin
            if (state == WAIT_I) begin
              if_valid <= 1'b1;
              if_err   <= ~mem_valid;
              if_rdata <= mem_valid ? mem_read_data : '0;
            end else begin
              d_valid <= 1'b1;
              d_err   <= ~mem_valid;
              d_rdata <= mem_valid ? mem_read_data : '0;
            end
            state <= IDLE;
          end else
            cnt <= cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven single transactions plus contention, reset-abort and late-response sequences
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid, if_err;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [7:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_mask = '0;
  logic [31:0] d_rdata;
  logic        d_valid, d_err;
  logic        mem_request, mem_w_en;
  logic [7:0]  mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_masking;
  logic [31:0] mem_read_data = '0;
  logic        mem_valid = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_if, last_d;

  typedef struct {
    logic        dp;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    int          lat;
    logic        e_we;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_edges;
  } vec_t;
  vec_t tbl [8];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
    .mem_request(mem_request), .mem_address(mem_address), .mem_w_en(mem_w_en),
    .mem_write_data(mem_write_data), .mem_masking(mem_masking),
    .mem_read_data(mem_read_data), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] all_outs();
    return {14'd0, mem_request, mem_address, mem_w_en, mem_write_data, mem_masking,
            if_valid, if_err, d_valid, d_err, if_rdata, d_rdata};
  endfunction

  task automatic run_txn(input vec_t v);
    int  n;
    int  k;
    logic got;
    if_addr = v.addr;
    d_addr  = v.addr;
    d_we    = v.we;
    d_wdata = v.wdata;
    d_mask  = v.mask;
    if (v.dp) d_req = 1'b1; else if_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!mem_request && n < 10);
    check("issue_lat", n, 1);
    check("mem_address", mem_address, v.addr);
    check("mem_w_en", mem_w_en, v.e_we);
    check("mem_masking", mem_masking, v.e_mask);
    check("mem_write_data", mem_write_data, v.e_wdata);
    k = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      mem_valid     = (v.lat != 0) && (k == v.lat);
      mem_read_data = v.rdata;
      tick();
      k++;
      mem_valid = 1'b0;
      got = v.dp ? d_valid : if_valid;
    end
    check("valid_seen", got, 1);
    check("req_to_valid_edges", k + 1, v.e_edges);
    check("rdata", v.dp ? d_rdata : if_rdata, v.e_rdata);
    check("err", v.dp ? d_err : if_err, v.e_err);
    check("other_valid", v.dp ? if_valid : d_valid, 0);
    check("other_rdata_hold", v.dp ? if_rdata : d_rdata, v.dp ? last_if : last_d);
    check("addr_stable", {mem_request, mem_address, mem_w_en, mem_masking},
          {1'b0, v.addr, v.e_we, v.e_mask});
    if (v.dp) last_d = v.e_rdata; else last_if = v.e_rdata;
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
  endtask

  initial begin
    int   n, r, first, issues;
    logic pend, bad;
    logic [3:0] ord;
    //            dp  we  addr   wdata          mask  rdata          lat e_we e_mask e_wdata        e_rdata        err edges
    tbl[0] = '{1'b0, 1'b0, 8'h04, 32'hFFFF0000, 4'hF, 32'h00000013, 1,  1'b0, 4'h0, 32'h0,         32'h00000013, 1'b0, 3};
    tbl[1] = '{1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 4'h3, 32'hCAFE0001, 2,  1'b1, 4'h3, 32'hDEADBEEF,  32'hCAFE0001, 1'b0, 4};
    tbl[2] = '{1'b1, 1'b0, 8'h22, 32'h11111111, 4'hF, 32'h12345678, 3,  1'b0, 4'h0, 32'h11111111,  32'h12345678, 1'b0, 5};
    tbl[3] = '{1'b1, 1'b0, 8'h5A, 32'h0,        4'h0, 32'hFFFFFFFF, 0,  1'b0, 4'h0, 32'h0,         32'h0,        1'b1, 17};
    tbl[4] = '{1'b0, 1'b0, 8'hFF, 32'h0,        4'h0, 32'hA5A5A5A5, 1,  1'b0, 4'h0, 32'h0,         32'hA5A5A5A5, 1'b0, 3};
    tbl[5] = '{1'b1, 1'b1, 8'h7F, 32'h0BADF00D, 4'h8, 32'h5555AAAA, 15, 1'b1, 4'h8, 32'h0BADF00D,  32'h5555AAAA, 1'b0, 17};
    tbl[6] = '{1'b0, 1'b0, 8'h01, 32'h0,        4'h0, 32'h77777777, 0,  1'b0, 4'h0, 32'h0,         32'h0,        1'b1, 17};
    tbl[7] = '{1'b0, 1'b1, 8'h02, 32'h12345678, 4'hF, 32'h89ABCDEF, 15, 1'b0, 4'h0, 32'h0,         32'h89ABCDEF, 1'b0, 17};

    repeat (2) tick();
    check("reset_outputs", all_outs(), 0);

    if_addr = 8'h40;
    d_addr  = 8'h80;
    d_we    = 1'b0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    rst     = 1'b1;
    n = 0; r = 0; first = -1; issues = 0; pend = 1'b0; ord = '0; bad = 1'b0;
    for (int it = 1; it <= 40 && n < 4; it++) begin
      tick();
      mem_valid = 1'b0;
      if (pend) begin
        mem_valid     = 1'b1;
        mem_read_data = 32'h100 + r;
        r++;
        pend = 1'b0;
      end
      if (mem_request) begin
        pend = 1'b1;
        if (first < 0) first = it;
        check("rr_issue_addr", mem_address, issues[0] ? 8'h80 : 8'h40);
        issues++;
      end
      if (if_valid && d_valid) bad = 1'b1;
      if (if_valid || d_valid) begin
        ord[3-n] = d_valid;
        check("rr_rdata", d_valid ? d_rdata : if_rdata, 32'h100 + n);
        n++;
        if (n == 4) begin
          if_req = 1'b0;
          d_req  = 1'b0;
        end
      end
    end
    mem_valid = 1'b0;
    check("rr_first_grant_edge", first, 1);
    check("rr_count", n, 4);
    check("rr_order", ord, 4'b0101);
    check("rr_no_dual_valid", bad, 0);
    last_if = 32'h102;
    last_d  = 32'h103;
    tick();

    mem_valid     = 1'b1;
    mem_read_data = 32'hBAD0BAD0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      mem_valid = 1'b0;
      if (if_valid || d_valid || mem_request) bad = 1'b1;
    end
    check("late_resp_ignored", bad, 0);

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    if_addr = 8'h33;
    if_req  = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!mem_request && n < 10);
    check("abort_issue", mem_request, 1);
    tick();
    rst    = 1'b0;
    if_req = 1'b0;
    #1;
    check("abort_async_outs", all_outs(), 0);
    repeat (2) tick();
    rst = 1'b1;
    mem_valid     = 1'b1;
    mem_read_data = 32'h0F0F0F0F;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      mem_valid = 1'b0;
      if (if_valid || d_valid || mem_request) bad = 1'b1;
    end
    check("abort_no_valid", bad, 0);
    check("abort_outs_zero", all_outs(), 0);
    last_if = 32'h0;
    last_d  = 32'h0;
    run_txn(tbl[0]);
    run_txn(tbl[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
